// File: rtl/nbody_pkg.sv
// rtl/nbody_pkg.sv - shared body/force types and defaults for the n-body force scheduler
package nbody_pkg;

   localparam int FORCE_W         = 32;
   localparam int N_DEFAULT       = 16;
   localparam int LATENCY_DEFAULT = 6;
   localparam int MAX_BODIES      = 256;

   typedef logic [$clog2(MAX_BODIES)-1:0] body_t;
   typedef logic [FORCE_W-1:0]            force_t;

   typedef struct packed {
      force_t fx;
      force_t fy;
   } force_vec_t;

   // Number of ordered (target, source) pairs in one full pass.
   function automatic int pair_count(input int n);
      return n * (n - 1);
   endfunction

endpackage

// File: rtl/pair_scheduler_if.sv
// rtl/pair_scheduler_if.sv - pair issue and force result bus between scheduler and force pipeline
interface pair_scheduler_if
   import nbody_pkg::*;
#(
   parameter int ADDR_WIDTH = $clog2(N_DEFAULT)
);

   logic                  pair_valid;
   logic [ADDR_WIDTH-1:0] pair_i;
   logic [ADDR_WIDTH-1:0] pair_j;
   logic                  res_valid;
   force_t                res_fx;
   force_t                res_fy;

   modport master (
      output pair_valid, pair_i, pair_j,
      input  res_valid, res_fx, res_fy
   );

   modport slave (
      input  pair_valid, pair_i, pair_j,
      output res_valid, res_fx, res_fy
   );

endinterface

// File: rtl/pair_index_gen.sv
// rtl/pair_index_gen.sv - row-major (i,j) pair counter that skips j==i without a bubble
module pair_index_gen
   import nbody_pkg::*;
#(
   parameter int N          = N_DEFAULT,
   parameter int ADDR_WIDTH = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  restart_i,
   input  logic                  advance_i,
   output logic [ADDR_WIDTH-1:0] pair_i_o,
   output logic [ADDR_WIDTH-1:0] pair_j_o,
   output logic                  last_o
);

   localparam int CW = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] i_q, i_d;
   logic [ADDR_WIDTH-1:0] j_q, j_d;
   logic [ADDR_WIDTH-1:0] cur_i, cur_j;
   logic [CW-1:0]         j_inc, j_skip;

   // restart presents (0,1) combinationally so the first pair can issue on the start edge
   always_comb begin
      cur_i = restart_i ? '0 : i_q;
      cur_j = restart_i ? ADDR_WIDTH'(1) : j_q;

      j_inc  = {1'b0, cur_j} + CW'(1);
      j_skip = (j_inc == {1'b0, cur_i}) ? j_inc + CW'(1) : j_inc;

      i_d = cur_i;
      j_d = cur_j;
      if (advance_i) begin
         if (j_skip >= CW'(N)) begin
            i_d = cur_i + ADDR_WIDTH'(1);
            j_d = '0;
         end else begin
            j_d = j_skip[ADDR_WIDTH-1:0];
         end
      end
   end

   assign pair_i_o = cur_i;
   assign pair_j_o = cur_j;
   assign last_o   = (cur_i == ADDR_WIDTH'(N - 1)) && (cur_j == ADDR_WIDTH'(N - 2));

   always_ff @(posedge clk) begin
      if (reset) begin
         i_q <= '0;
         j_q <= '0;
      end else begin
         i_q <= i_d;
         j_q <= j_d;
      end
   end

endmodule

// File: rtl/pair_scheduler.sv
// rtl/pair_scheduler.sv - issues all N*(N-1) body pairs and accumulates returned forces per row
module pair_scheduler
   import nbody_pkg::*;
#(
   parameter int N          = N_DEFAULT,
   parameter int LATENCY    = LATENCY_DEFAULT,
   parameter int ADDR_WIDTH = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  hold,
   pair_scheduler_if.master      bus,
   output logic                  acc_valid,
   output logic [ADDR_WIDTH-1:0] acc_i,
   output force_t                acc_fx,
   output force_t                acc_fy,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int OUT_W = $clog2(N * N + 1);
   // Results are matched purely by order, so the pipeline depth never enters the logic.
   localparam int unused_latency = LATENCY;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  pair_valid_q, pair_valid_d;
   logic [ADDR_WIDTH-1:0] pair_i_q, pair_i_d;
   logic [ADDR_WIDTH-1:0] pair_j_q, pair_j_d;
   logic [ADDR_WIDTH-1:0] row_q, row_d;
   logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
   logic [OUT_W-1:0]      out_q, out_d;
   force_vec_t            sum_q, sum_d, acc_q, acc_d, sum_add;
   logic                  acc_valid_q, acc_valid_d;
   logic [ADDR_WIDTH-1:0] acc_i_q, acc_i_d;
   logic                  err_q, err_d;
   logic                  flush_q, flush_d;

   logic                  in_pass, start_ok, issue_fire;
   logic                  res_ok, res_bad, row_end, pass_end;
   logic [ADDR_WIDTH-1:0] gen_i, gen_j;
   logic                  gen_last;

   pair_index_gen #(
      .N          (N),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_index_gen (
      .clk       (clk),
      .reset     (reset),
      .restart_i (start_ok),
      .advance_i (issue_fire),
      .pair_i_o  (gen_i),
      .pair_j_o  (gen_j),
      .last_o    (gen_last)
   );

   // flush_q marks an IDLE entered by resetting a live pass: stragglers from it are dropped silently
   always_comb begin
      in_pass    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
      issue_fire = !hold && (start_ok || (state_q == S_ISSUE));
      res_ok     = bus.res_valid && in_pass && (out_q != '0);
      res_bad    = bus.res_valid && !res_ok && !(flush_q && (state_q == S_IDLE));
      row_end    = res_ok && (row_cnt_q == ADDR_WIDTH'(N - 2));
      pass_end   = row_end && (row_q == ADDR_WIDTH'(N - 1));
      sum_add.fx = sum_q.fx + bus.res_fx;
      sum_add.fy = sum_q.fy + bus.res_fy;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start_ok) state_d = S_ISSUE;
         S_ISSUE:        if (issue_fire && gen_last) state_d = S_DRAIN;
         S_DRAIN:        if (pass_end) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pair_valid_d = issue_fire;
      pair_i_d     = issue_fire ? gen_i : pair_i_q;
      pair_j_d     = issue_fire ? gen_j : pair_j_q;

      case ({issue_fire, res_ok})
         2'b10:   out_d = out_q + OUT_W'(1);
         2'b01:   out_d = out_q - OUT_W'(1);
         default: out_d = out_q;
      endcase

      sum_d       = sum_q;
      row_d       = row_q;
      row_cnt_d   = row_cnt_q;
      acc_valid_d = 1'b0;
      acc_i_d     = acc_i_q;
      acc_d       = acc_q;
      if (start_ok) begin
         sum_d     = '0;
         row_d     = '0;
         row_cnt_d = '0;
      end else if (res_ok) begin
         if (row_end) begin
            acc_valid_d = 1'b1;
            acc_i_d     = row_q;
            acc_d       = sum_add;
            sum_d       = '0;
            row_cnt_d   = '0;
            row_d       = row_q + ADDR_WIDTH'(1);
         end else begin
            sum_d     = sum_add;
            row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
         end
      end

      err_d   = err_q || res_bad;
      flush_d = start_ok ? 1'b0 : flush_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pair_valid_q <= 1'b0;
         pair_i_q     <= '0;
         pair_j_q     <= '0;
         row_q        <= '0;
         row_cnt_q    <= '0;
         out_q        <= '0;
         sum_q        <= '0;
         acc_q        <= '0;
         acc_valid_q  <= 1'b0;
         acc_i_q      <= '0;
         err_q        <= 1'b0;
         flush_q      <= in_pass || flush_q;
      end else begin
         state_q      <= state_d;
         pair_valid_q <= pair_valid_d;
         pair_i_q     <= pair_i_d;
         pair_j_q     <= pair_j_d;
         row_q        <= row_d;
         row_cnt_q    <= row_cnt_d;
         out_q        <= out_d;
         sum_q        <= sum_d;
         acc_q        <= acc_d;
         acc_valid_q  <= acc_valid_d;
         acc_i_q      <= acc_i_d;
         err_q        <= err_d;
         flush_q      <= flush_d;
      end
   end

   assign bus.pair_valid = pair_valid_q;
   assign bus.pair_i     = pair_i_q;
   assign bus.pair_j     = pair_j_q;
   assign acc_valid      = acc_valid_q;
   assign acc_i          = acc_i_q;
   assign acc_fx         = acc_q.fx;
   assign acc_fy         = acc_q.fy;
   assign busy           = in_pass;
   assign done           = (state_q == S_DONE);
   assign err            = err_q;

endmodule

// File: tb/tb_pair_scheduler.sv
// tb/tb_pair_scheduler.sv - scoreboard bench for pair_scheduler at N=4 and N=2
module tb_pair_scheduler;
   import nbody_pkg::*;

   localparam int LAT = 6;

   typedef struct packed { body_t i; body_t j; } pair_t;
   typedef struct packed { body_t i; force_t fx; force_t fy; } acc_t;
   typedef struct packed { int due; body_t i; body_t j; } inflight_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst_v = 2'b11, start_v = 2'b00, hold_v = 2'b00, rv_v = 2'b00, inj_v = 2'b00;
   logic [1:0] pv_v, av_v, busy_v, done_v, err_v;
   body_t      pi_w [2], pj_w [2], ai_w [2];
   force_t     rfx [2], rfy [2], afx [2], afy [2];
   force_t     tab_fx [2][4][4], tab_fy [2][4][4];

   pair_t      exp_pair [2][$];
   acc_t       exp_acc  [2][$];
   inflight_t  pipe     [2][$];
   int         pairs_seen [2], first_pv [2], last_pv [2];
   int         cyc = 0, pcyc = 0;
   int         checks = 0, errors = 0;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int NK  = (k == 0) ? 4 : 2;
      localparam int AWK = $clog2(NK);
      pair_scheduler_if #(.ADDR_WIDTH(AWK)) bus ();
      logic [AWK-1:0] acc_i_w;

      pair_scheduler #(.N(NK), .LATENCY(LAT), .ADDR_WIDTH(AWK)) u_dut (
         .clk       (clk),
         .reset     (rst_v[k]),
         .start     (start_v[k]),
         .hold      (hold_v[k]),
         .bus       (bus),
         .acc_valid (av_v[k]),
         .acc_i     (acc_i_w),
         .acc_fx    (afx[k]),
         .acc_fy    (afy[k]),
         .busy      (busy_v[k]),
         .done      (done_v[k]),
         .err       (err_v[k])
      );

      assign pv_v[k]       = bus.pair_valid;
      assign pi_w[k]       = body_t'(bus.pair_i);
      assign pj_w[k]       = body_t'(bus.pair_j);
      assign ai_w[k]       = body_t'(acc_i_w);
      assign bus.res_valid = rv_v[k];
      assign bus.res_fx    = rfx[k];
      assign bus.res_fy    = rfy[k];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Force pipeline model: every issued pair returns its table entry exactly LAT cycles later.
   initial begin
      for (int k = 0; k < 2; k++) begin
         rfx[k] = '0;
         rfy[k] = '0;
      end
      forever begin
         @(posedge clk);
         #1;
         pcyc++;
         for (int k = 0; k < 2; k++) begin
            inflight_t e;
            if (pv_v[k]) pipe[k].push_back('{due: pcyc + LAT, i: pi_w[k], j: pj_w[k]});
            rv_v[k] = inj_v[k];
            rfx[k]  = '0;
            rfy[k]  = '0;
            if (pipe[k].size() > 0 && pipe[k][0].due == pcyc) begin
               e       = pipe[k].pop_front();
               rv_v[k] = 1'b1;
               rfx[k]  = tab_fx[k][e.i[1:0]][e.j[1:0]];
               rfy[k]  = tab_fy[k][e.i[1:0]][e.j[1:0]];
            end
         end
      end
   end

   // Monitor: compare every presented pair and accumulated force with the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) begin
            pair_t p;
            acc_t  a;
            if (pv_v[k]) begin
               if (pairs_seen[k] == 0) first_pv[k] = cyc;
               last_pv[k] = cyc;
               pairs_seen[k]++;
               if (exp_pair[k].size() == 0) check("unexpected_pair", pv_v[k], 0);
               else begin
                  p = exp_pair[k].pop_front();
                  check("pair_i", pi_w[k], p.i);
                  check("pair_j", pj_w[k], p.j);
               end
            end
            if (av_v[k]) begin
               if (exp_acc[k].size() == 0) check("unexpected_acc", av_v[k], 0);
               else begin
                  a = exp_acc[k].pop_front();
                  check("acc_i", ai_w[k], a.i);
                  check("acc_fx", afx[k], a.fx);
                  check("acc_fy", afy[k], a.fy);
                  check("done_with_final_acc", done_v[k], exp_acc[k].size() == 0);
               end
            end
         end
      end
   end

   function automatic int n_of(input int k);
      return (k == 0) ? 4 : 2;
   endfunction

   // mode 0: fx=j fy=-j, mode 1: random, mode 2: fx=0x7FFFFFFF with random fy
   task automatic begin_pass(input int k, input int mode);
      int     n = n_of(k);
      force_t sx, sy;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++) begin
            case (mode)
               0:       begin tab_fx[k][i][j] = force_t'(j);     tab_fy[k][i][j] = force_t'(-j); end
               1:       begin tab_fx[k][i][j] = $urandom();      tab_fy[k][i][j] = $urandom();   end
               default: begin tab_fx[k][i][j] = 32'h7FFF_FFFF;   tab_fy[k][i][j] = $urandom();   end
            endcase
         end
      for (int i = 0; i < n; i++) begin
         sx = '0;
         sy = '0;
         for (int j = 0; j < n; j++) begin
            if (j == i) continue;
            exp_pair[k].push_back('{i: body_t'(i), j: body_t'(j)});
            sx = sx + tab_fx[k][i][j];
            sy = sy + tab_fy[k][i][j];
         end
         exp_acc[k].push_back('{i: body_t'(i), fx: sx, fy: sy});
      end
      pairs_seen[k] = 0;
      @(posedge clk); #1;
      start_v[k] = 1'b1;
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      check("first_pair_valid", pv_v[k], 1);
      check("done_low_after_start", done_v[k], 0);
      check("busy_after_start", busy_v[k], 1);
   endtask

   task automatic wait_done(input int k, input bit rand_hold);
      int c = 0;
      while (!done_v[k] && c < 500) begin
         @(posedge clk); #1;
         hold_v[k] = rand_hold && ($urandom_range(0, 3) == 0);
         c++;
      end
      hold_v[k] = 1'b0;
      check("pass_completes", done_v[k], 1);
      @(negedge clk); #1;
      check("pairs_left", exp_pair[k].size(), 0);
      check("accs_left", exp_acc[k].size(), 0);
      check("pair_count", pairs_seen[k], pair_count(n_of(k)));
      check("busy_in_done", busy_v[k], 0);
   endtask

   task automatic wait_pairs(input int k, input int m);
      int c = 0;
      while (pairs_seen[k] < m && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      check("pairs_reached", pairs_seen[k] >= m, 1);
   endtask

   task automatic check_idle_outputs(input int k, input logic exp_err);
      check("rst_pair_valid", pv_v[k], 0);
      check("rst_pair_i", pi_w[k], 0);
      check("rst_pair_j", pj_w[k], 0);
      check("rst_acc_valid", av_v[k], 0);
      check("rst_acc_i", ai_w[k], 0);
      check("rst_acc_fx", afx[k], 0);
      check("rst_acc_fy", afy[k], 0);
      check("rst_busy", busy_v[k], 0);
      check("rst_done", done_v[k], 0);
      check("rst_err", err_v[k], exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_v = 2'b00;
      check_idle_outputs(0, 1'b0);
      check_idle_outputs(1, 1'b0);

      begin_pass(0, 0);
      wait_done(0, 1'b0);
      check("issue_span_n4", last_pv[0] - first_pv[0], 11);

      begin_pass(0, 1);
      wait_done(0, 1'b0);
      check("issue_span_restart", last_pv[0] - first_pv[0], 11);

      begin_pass(0, 0);
      wait_pairs(0, 5);
      hold_v[0] = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      hold_v[0] = 1'b0;
      wait_done(0, 1'b0);
      check("issue_span_hold3", last_pv[0] - first_pv[0], 14);

      for (int r = 0; r < 2; r++) begin
         begin_pass(0, 1);
         wait_done(0, 1'b1);
      end

      begin_pass(1, 2);
      wait_done(1, 1'b0);
      check("issue_span_n2", last_pv[1] - first_pv[1], 1);
      begin_pass(1, 1);
      wait_done(1, 1'b1);

      rst_v[1] = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst_v[1] = 1'b0;
      check_idle_outputs(1, 1'b0);
      inj_v[1] = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      inj_v[1] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("err_idle_result", err_v[1], 1);
      begin_pass(1, 1);
      wait_done(1, 1'b0);
      check("err_sticky", err_v[1], 1);

      begin_pass(0, 0);
      wait_pairs(0, 7);
      rst_v[0] = 1'b1;
      @(posedge clk); #1;
      rst_v[0] = 1'b0;
      exp_pair[0].delete();
      exp_acc[0].delete();
      check_idle_outputs(0, 1'b0);
      repeat (LAT + 4) begin @(posedge clk); #1; end
      check("err_after_late_results", err_v[0], 0);
      check("late_results_no_acc", ai_w[0], 0);
      begin_pass(0, 0);
      wait_done(0, 1'b0);
      check("err_clean_n4", err_v[0], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
